cmp_iter_seq: RTL and testbench
===============================

Name: cmp_iter_seq

Overview:
Parametrised, multi-cycle magnitude comparator that returns the standard 2-bit ordering code (GT/LT/EQ) over a valid/ready handshake. It scans the operands MSB-chunk first, CHUNK bits per cycle, and stops early at the first differing chunk. It supports unsigned and two's-complement signed modes. It sits beside the ALU and branch unit for wide compares where a single-cycle 64-bit compare chain would limit timing.

Parameters:
WIDTH, 64, operand width in bits; must be a multiple of CHUNK.
CHUNK, 16, bits compared per cycle; CHUNK==WIDTH gives a single-pass compare.
NCHUNK, WIDTH/CHUNK, derived localparam; IDXW = max(1, clog2(NCHUNK)).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous cancel of the operation in flight
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
is_signed  in  1  1 = two's-complement compare, sampled with operands
op1  in  WIDTH  first operand
op2  in  WIDTH  second operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
res  out  2  01 = op1>op2, 10 = op1<op2, 11 = equal, 00 = no result
diff_idx  out  IDXW  index of the chunk that decided the result; 0 when equal

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, res=00, diff_idx=0, operand registers cleared.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready, register op1/op2 and set idx=NCHUNK-1, then go to BUSY.
  - If is_signed=1, invert bit WIDTH-1 of both operands at capture (sign bias). This lets an unsigned scan give the signed order.
- BUSY: each cycle, compare chunk idx of the two registered operands (bits idx*CHUNK+CHUNK-1 : idx*CHUNK).
  - Chunks differ: res = GT or LT by unsigned chunk order, diff_idx=idx, go to DONE.
  - Chunks equal and idx==0: res=11, diff_idx=0, go to DONE.
  - Otherwise: idx decrements and the block stays in BUSY.
- Latency: out_valid rises k cycles after the acceptance edge. k = NCHUNK - diff_idx for an unequal result, and NCHUNK for an equal result (1..NCHUNK).
- DONE: res and diff_idx are held stable while out_valid && !out_ready. On out_ready, go to IDLE with res=00.
  - The next operands can be accepted one cycle later, so the throughput ceiling is one result per k+2 cycles.
- in_valid while in_ready=0 is ignored. There is no buffering; the upstream holds its operands.
- abort (synchronous) in BUSY or DONE: next state is IDLE, out_valid=0, res=00. An undelivered result is discarded. abort in IDLE has no effect, and abort wins over acceptance in the same cycle.
- Reset asserted mid-BUSY or mid-DONE forces all outputs to reset values immediately. No result is produced for the lost operation.
- CHUNK==WIDTH: every compare takes exactly 1 BUSY cycle and diff_idx is always 0.

Decomposition:
- Shared `define header holds the result codes OP1_GT_OP2=2'b01, OP1_LT_OP2=2'b10, OP1_EQ_OP2=2'b11, RES_NONE=2'b00, plus the FSM state encodings.
- One combinational sub-module, cmp_chunk_unit #(CHUNK): takes a[CHUNK], b[CHUNK] and returns the 2-bit code.
- cmp_iter_seq owns the FSM, operand registers, the idx counter, the chunk mux and the handshake.

Test Plan:
All scenarios use WIDTH=64, CHUNK=16.
1. Unsigned LSB-chunk decision: op1=0x0000_0000_0000_0005, op2=0x0000_0000_0000_0003, is_signed=0 -> res=01, diff_idx=0, out_valid 4 cycles after accept.
2. Sign mode at the MSB chunk: op1=0x8000_0000_0000_0000, op2=0x0000_0000_0000_0001.
   - is_signed=0 -> res=01, diff_idx=3, out_valid 1 cycle after accept.
   - is_signed=1 -> res=10, diff_idx=3.
3. Equal and signed-negative cases:
   - op1=op2=0xDEAD_BEEF_CAFE_BABE -> res=11, diff_idx=0, 4 cycles.
   - Signed op1=0xFFFF_FFFF_FFFF_FFFF (-1), op2=0xFFFF_FFFF_FFFF_FFFE (-2) -> res=01, 4 cycles.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 with res/diff_idx stable, in_ready=0, and in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1, res=00.
5. Abort: pulse abort on the 2nd BUSY cycle of an equal-operand compare -> out_valid never rises, IDLE next cycle. A subsequent compare of 7 vs 9 returns res=10.
6. Reset: drop rst_n asynchronously mid-BUSY -> out_valid=0, res=00, in_ready=1 without waiting for a clock edge. After release, a compare of 0x10 vs 0x10 returns res=11.

Source files
------------

// File: rtl/cmp_iter_seq_pkg.sv
// Shared definitions for the iterative magnitude comparator:
// result codes, FSM state encoding and an index-width helper.
package cmp_iter_seq_pkg;

   // Ordering codes returned on res
   localparam logic [1:0] OP1_GT_OP2 = 2'b01;
   localparam logic [1:0] OP1_LT_OP2 = 2'b10;
   localparam logic [1:0] OP1_EQ_OP2 = 2'b11;
   localparam logic [1:0] RES_NONE   = 2'b00;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Chunk index width; a single chunk still needs a 1-bit index port
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/cmp_chunk_unit.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module cmp_chunk_unit
   import cmp_iter_seq_pkg::*;
#(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic [1:0]       code
);

   // Produce the ordering code for this slice
   always_comb begin
      code = OP1_EQ_OP2;
      if (a > b)
         code = OP1_GT_OP2;
      else if (a < b)
         code = OP1_LT_OP2;
   end

endmodule

// File: rtl/cmp_iter_seq.sv
// Multi-cycle magnitude comparator. Operands are scanned MSB chunk first,
// one chunk per cycle, stopping at the first differing chunk. Signed mode
// flips the sign bit of both operands at capture so the unsigned scan
// yields the two's-complement ordering.
module cmp_iter_seq
   import cmp_iter_seq_pkg::*;
#(
   parameter  int WIDTH  = 64,
   parameter  int CHUNK  = 16,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int IDXW   = idx_width(NCHUNK)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       res,
   output logic [IDXW-1:0]  diff_idx
);

   state_t            r_state;
   logic [WIDTH-1:0]  r_op1;
   logic [WIDTH-1:0]  r_op2;
   logic [IDXW-1:0]   r_idx;
   logic [1:0]        r_res;
   logic [IDXW-1:0]   r_diff_idx;

   logic [WIDTH-1:0]  w_bias;
   logic [CHUNK-1:0]  w_a_chunks [NCHUNK];
   logic [CHUNK-1:0]  w_b_chunks [NCHUNK];
   logic [CHUNK-1:0]  w_a_sel;
   logic [CHUNK-1:0]  w_b_sel;
   logic [1:0]        w_chunk_code;

   // Only the sign bit is inverted, and only for signed compares
   assign w_bias = {is_signed, {(WIDTH-1){1'b0}}};

   // Slice both registered operands into chunks for the per-cycle mux
   for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign w_a_chunks[gi] = r_op1[gi*CHUNK +: CHUNK];
      assign w_b_chunks[gi] = r_op2[gi*CHUNK +: CHUNK];
   end

   assign w_a_sel = w_a_chunks[r_idx];
   assign w_b_sel = w_b_chunks[r_idx];

   cmp_chunk_unit #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a    (w_a_sel),
      .b    (w_b_sel),
      .code (w_chunk_code)
   );

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign res       = r_res;
   assign diff_idx  = r_diff_idx;

   // Controller: capture, chunk scan, result hold, abort and handshake.
   // An abort in IDLE blocks a same-cycle acceptance but otherwise does nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_op1      <= '0;
         r_op2      <= '0;
         r_idx      <= '0;
         r_res      <= RES_NONE;
         r_diff_idx <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && !abort) begin
                  r_op1   <= op1 ^ w_bias;
                  r_op2   <= op2 ^ w_bias;
                  r_idx   <= IDXW'(NCHUNK - 1);
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (abort) begin
                  r_res   <= RES_NONE;
                  r_state <= ST_IDLE;
               end else if (w_chunk_code != OP1_EQ_OP2) begin
                  r_res      <= w_chunk_code;
                  r_diff_idx <= r_idx;
                  r_state    <= ST_DONE;
               end else if (r_idx == '0) begin
                  r_res      <= OP1_EQ_OP2;
                  r_diff_idx <= '0;
                  r_state    <= ST_DONE;
               end else begin
                  r_idx <= r_idx - IDXW'(1);
               end
            end
            ST_DONE: begin
               if (abort || out_ready) begin
                  r_res      <= RES_NONE;
                  r_diff_idx <= '0;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_res   <= RES_NONE;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_iter_seq.sv
// Bench for cmp_iter_seq (WIDTH=64, CHUNK=16): directed and random compares
// checked against a plain-arithmetic ordering model, plus backpressure,
// abort and asynchronous reset scenarios.
module tb_cmp_iter_seq;

   localparam int WIDTH  = 64;
   localparam int CHUNK  = 16;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              abort = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              is_signed = 1'b0;
   logic [WIDTH-1:0]  op1 = '0;
   logic [WIDTH-1:0]  op2 = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [1:0]        res;
   logic [1:0]        diff_idx;

   int checks = 0;
   int errors = 0;

   cmp_iter_seq #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_signed (is_signed),
      .op1       (op1),
      .op2       (op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .diff_idx  (diff_idx)
   );

   always #5 clk = ~clk;

   // Reference: ordering from integer compare, deciding chunk from the
   // highest differing bit, latency from the number of chunks scanned.
   function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, output logic [1:0] r, output int idx,
                                 output int lat);
      logic [WIDTH-1:0] x;
      bit gt;
      int msb;
      if (a == b) begin
         r = 2'b11; idx = 0; lat = NCHUNK;
         return;
      end
      gt = s ? ($signed(a) > $signed(b)) : (a > b);
      r = gt ? 2'b01 : 2'b10;
      x = a ^ b;
      msb = 0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x[i]) begin
            msb = i;
            break;
         end
      end
      idx = msb / CHUNK;
      lat = NCHUNK - idx;
   endfunction

   // Present operands at a negedge and return at the negedge after acceptance
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL start_ready: in_ready=%0b required 1 within 50 cycles", in_ready);
      end
      op1 = a; op2 = b; is_signed = s; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count cycles from acceptance until out_valid is seen (-1 on timeout)
   task automatic wait_result(output int lat);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++;
      if (res !== 2'b00) begin errors++; $display("FAIL reset_res: got %b want 00", res); end
      checks++;
      if (diff_idx !== 2'd0) begin errors++; $display("FAIL reset_diff_idx: got %0d want 0", diff_idx); end
      $display("reset: in_ready=%0b out_valid=%0b res=%b diff_idx=%0d", in_ready, out_valid, res, diff_idx);
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] ta [6] = '{64'h5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                   64'hDEAD_BEEF_CAFE_BABE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7};
      logic [WIDTH-1:0] tb [6] = '{64'h3, 64'h1, 64'h1,
                                   64'hDEAD_BEEF_CAFE_BABE, 64'hFFFF_FFFF_FFFF_FFFE, 64'h9};
      logic ts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] sr [6] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
      int sl [6] = '{4, 1, 1, 4, 4, 4};
      logic [1:0] er;
      int ei, el, lat;
      for (int t = 0; t < 6; t++) begin
         model(ta[t], tb[t], ts[t], er, ei, el);
         start_op(ta[t], tb[t], ts[t]);
         wait_result(lat);
         checks++;
         if (res !== sr[t] || res !== er) begin
            errors++; $display("FAIL dir_res[%0d]: got %b want %b", t, res, sr[t]);
         end
         checks++;
         if (diff_idx !== 2'(ei)) begin
            errors++; $display("FAIL dir_idx[%0d]: got %0d want %0d", t, diff_idx, ei);
         end
         checks++;
         if (lat != sl[t] || lat != el) begin
            errors++; $display("FAIL dir_lat[%0d]: got %0d want %0d", t, lat, sl[t]);
         end
         $display("directed %0d: op1=%h op2=%h s=%0b res=%b idx=%0d lat=%0d", t, ta[t], tb[t], ts[t], res, diff_idx, lat);
         release_result();
         checks++;
         if (in_ready !== 1'b1 || res !== 2'b00) begin
            errors++; $display("FAIL dir_release[%0d]: in_ready=%0b res=%b want 1/00", t, in_ready, res);
         end
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      logic s;
      logic [1:0] er;
      int ei, el, lat, k;
      for (int t = 0; t < 40; t++) begin
         a = {$urandom(), $urandom()};
         b = a;
         k = $urandom_range(0, 4);
         if (k < 4) b[k*CHUNK +: CHUNK] = 16'($urandom());
         if ($urandom_range(0, 3) == 0) b = {$urandom(), $urandom()};
         s = 1'($urandom_range(0, 1));
         model(a, b, s, er, ei, el);
         start_op(a, b, s);
         wait_result(lat);
         checks++;
         if (res !== er || diff_idx !== 2'(ei) || lat != el) begin
            errors++;
            $display("FAIL rand[%0d]: got res=%b idx=%0d lat=%0d want res=%b idx=%0d lat=%0d",
                     t, res, diff_idx, lat, er, ei, el);
         end
         $display("random %0d: op1=%h op2=%h s=%0b res=%b idx=%0d lat=%0d", t, a, b, s, res, diff_idx, lat);
         release_result();
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] er;
      int ei, el, lat;
      logic [WIDTH-1:0] a = 64'h1234_0000_0000_0000;
      logic [WIDTH-1:0] b = 64'h1234_0000_FFFF_0000;
      model(a, b, 1'b0, er, ei, el);
      start_op(a, b, 1'b0);
      wait_result(lat);
      checks++;
      if (res !== er || diff_idx !== 2'(ei) || lat != el) begin
         errors++; $display("FAIL bp_result: got res=%b idx=%0d lat=%0d want %b/%0d/%0d", res, diff_idx, lat, er, ei, el);
      end
      for (int c = 0; c < 5; c++) begin
         op1 = {$urandom(), $urandom()}; op2 = {$urandom(), $urandom()};
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== er || diff_idx !== 2'(ei)) begin
            errors++;
            $display("FAIL bp_hold[%0d]: ov=%0b ir=%0b res=%b idx=%0d want 1/0/%b/%0d", c, out_valid, in_ready, res, diff_idx, er, ei);
         end
      end
      $display("backpressure: held res=%b idx=%0d for 5 cycles", res, diff_idx);
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 2'b00) begin
         errors++; $display("FAIL bp_release: ir=%0b ov=%0b res=%b want 1/0/00", in_ready, out_valid, res);
      end
      // the ignored pulses must not have started a compare
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_no_capture: in_ready=%0b want 1", in_ready);
      end
   endtask

   task automatic test_abort();
      int lat;
      bit seen = 0;
      start_op(64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555, 1'b0);
      @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 2'b00) begin
         errors++; $display("FAIL abort_idle: ir=%0b ov=%0b res=%b want 1/0/00", in_ready, out_valid, res);
      end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_no_result: out_valid rose=1 want 0"); end
      start_op(64'd7, 64'd9, 1'b0);
      wait_result(lat);
      checks++;
      if (res !== 2'b10 || lat != 4) begin
         errors++; $display("FAIL abort_next: res=%b lat=%0d want 10/4", res, lat);
      end
      $display("abort: follow-up 7 vs 9 res=%b lat=%0d", res, lat);
      release_result();
   endtask

   task automatic test_async_reset();
      int lat;
      start_op(64'h10, 64'h10, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || res !== 2'b00 || in_ready !== 1'b1 || diff_idx !== 2'd0) begin
         errors++; $display("FAIL async_reset: ov=%0b res=%b ir=%0b idx=%0d want 0/00/1/0", out_valid, res, in_ready, diff_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_op(64'h10, 64'h10, 1'b0);
      wait_result(lat);
      checks++;
      if (res !== 2'b11 || diff_idx !== 2'd0 || lat != 4) begin
         errors++; $display("FAIL reset_next: res=%b idx=%0d lat=%0d want 11/0/4", res, diff_idx, lat);
      end
      $display("async reset: follow-up 0x10 vs 0x10 res=%b lat=%0d", res, lat);
      release_result();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_directed();
      test_random();
      test_backpressure();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
